alu_arbiter: RTL and testbench

Shares the single combinational ALU (and/or/add/sub/mul) between two requesters, e.g. the execute stage and a multi-cycle helper unit. The block grants round-robin, registers the operands driving the ALU and holds them for the op's latency. It captures the ALU result and returns it with the requester id over a valid/ready response channel. Multiply is treated as a multicycle path; every other op completes in one cycle.

---
 rtl/alu_arbiter_if.sv | 49 ++++
 rtl/alu_arbiter.sv | 145 ++++++++++++++
 tb/tb_alu_arbiter.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: groups the two requester channels, the ALU operand/result
// bus and the response channel shared between an alu_arbiter and its
// surroundings.
//   slave  modport: the arbiter side (takes requests, drives the ALU, responds)
//   master modport: the environment side (requesters, ALU, response consumer)
// Signal suffixes (_i/_o) are written from the arbiter's point of view.
interface alu_arbiter_if;
  // requester 0
  logic        req0_valid_i;
  logic        req0_ready_o;
  logic [31:0] req0_data1_i;
  logic [31:0] req0_data2_i;
  logic [2:0]  req0_ctrl_i;
  // requester 1
  logic        req1_valid_i;
  logic        req1_ready_o;
  logic [31:0] req1_data1_i;
  logic [31:0] req1_data2_i;
  logic [2:0]  req1_ctrl_i;
  // shared combinational ALU
  logic [31:0] alu_data1_o;
  logic [31:0] alu_data2_o;
  logic [2:0]  alu_ctrl_o;
  logic [31:0] alu_data_i;
  // response channel
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [31:0] rsp_data_o;
  logic        rsp_id_o;
  logic        busy_o;

  modport slave (
    input  req0_valid_i, req0_data1_i, req0_data2_i, req0_ctrl_i,
    input  req1_valid_i, req1_data1_i, req1_data2_i, req1_ctrl_i,
    input  alu_data_i, rsp_ready_i,
    output req0_ready_o, req1_ready_o,
    output alu_data1_o, alu_data2_o, alu_ctrl_o,
    output rsp_valid_o, rsp_data_o, rsp_id_o, busy_o
  );

  modport master (
    output req0_valid_i, req0_data1_i, req0_data2_i, req0_ctrl_i,
    output req1_valid_i, req1_data1_i, req1_data2_i, req1_ctrl_i,
    output alu_data_i, rsp_ready_i,
    input  req0_ready_o, req1_ready_o,
    input  alu_data1_o, alu_data2_o, alu_ctrl_o,
    input  rsp_valid_o, rsp_data_o, rsp_id_o, busy_o
  );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between two requesters.
// Requests are granted round-robin in IDLE; the accepted operands are
// registered onto the ALU bus and held while the op settles (MUL_LAT cycles
// for a multiply, one cycle otherwise). The ALU result is then captured and
// offered with the requester id on a valid/ready response channel.
// Ports:
//   clk_i  - clock, rising edge
//   rst_i  - asynchronous active-high reset
//   bus    - alu_arbiter_if.slave: request, ALU and response signals
// Parameters:
//   MUL_LAT - cycles the operands are held for a multiply (1..15)
module alu_arbiter #(
  parameter int unsigned MUL_LAT = 3
) (
  input  logic           clk_i,
  input  logic           rst_i,
  alu_arbiter_if.slave   bus
);

  localparam logic [2:0] CTRL_MUL = 3'b101;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_t;

  state_t      state;
  state_t      next_state;

  logic        last;        // id of the most recently accepted requester
  logic        id_q;        // id of the op in flight
  logic [3:0]  cnt;         // cycles left before the result is captured
  logic [31:0] alu_data1;
  logic [31:0] alu_data2;
  logic [2:0]  alu_ctrl;
  logic [31:0] rsp_data;
  logic        rsp_id;

  logic        grant0;
  logic        grant1;
  logic        accept;
  logic        capture;
  logic        ready0;
  logic        ready1;

  logic [31:0] sel_data1;
  logic [31:0] sel_data2;
  logic [2:0]  sel_ctrl;

  // Round-robin: a lone requester always wins; on a tie the one that was
  // not served last wins. last resets to 1 so requester 0 wins the first tie.
  assign grant0 = bus.req0_valid_i && (!bus.req1_valid_i || last);
  assign grant1 = bus.req1_valid_i && (!bus.req0_valid_i || !last);

  // grant1 doubles as the id of the accepted requester.
  assign sel_data1 = grant1 ? bus.req1_data1_i : bus.req0_data1_i;
  assign sel_data2 = grant1 ? bus.req1_data2_i : bus.req0_data2_i;
  assign sel_ctrl  = grant1 ? bus.req1_ctrl_i  : bus.req0_ctrl_i;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a variable unassigned and infer a latch.
  always_comb begin
    next_state = state;
    accept     = 1'b0;
    capture    = 1'b0;
    ready0     = 1'b0;
    ready1     = 1'b0;
    case (state)
      IDLE: begin
        // state resets asynchronously, but ready is combinational from the
        // valids, so it is masked explicitly while reset is held.
        ready0 = grant0 && !rst_i;
        ready1 = grant1 && !rst_i;
        if (grant0 || grant1) begin
          accept     = 1'b1;
          next_state = EXEC;
        end
      end
      EXEC: begin
        if (cnt == 4'd1) begin
          capture    = 1'b1;
          next_state = RESP;
        end
      end
      RESP: begin
        if (bus.rsp_ready_i) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Datapath registers. alu_* hold their value after the op completes so the
  // ALU inputs never toggle needlessly; only reset clears them.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      alu_data1 <= '0;
      alu_data2 <= '0;
      alu_ctrl  <= '0;
      id_q      <= 1'b0;
      last      <= 1'b1;
      cnt       <= '0;
      rsp_data  <= '0;
      rsp_id    <= 1'b0;
    end else begin
      if (accept) begin
        alu_data1 <= sel_data1;
        alu_data2 <= sel_data2;
        alu_ctrl  <= sel_ctrl;
        id_q      <= grant1;
        last      <= grant1;
        cnt       <= (sel_ctrl == CTRL_MUL) ? 4'(MUL_LAT) : 4'd1;
      end else if (state == EXEC) begin
        cnt <= cnt - 4'd1;
      end
      if (capture) begin
        rsp_data <= bus.alu_data_i;
        rsp_id   <= id_q;
      end
    end
  end

  assign bus.req0_ready_o = ready0;
  assign bus.req1_ready_o = ready1;
  assign bus.alu_data1_o  = alu_data1;
  assign bus.alu_data2_o  = alu_data2;
  assign bus.alu_ctrl_o   = alu_ctrl;
  assign bus.rsp_valid_o  = (state == RESP);
  assign bus.rsp_data_o   = rsp_data;
  assign bus.rsp_id_o     = rsp_id;
  assign bus.busy_o       = (state != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed self-checking bench for alu_arbiter (MUL_LAT=3).
// Provides a reference combinational ALU on the bus and walks through
// single ops, multiply latency, contention, backpressure, reset mid-op and
// arithmetic boundary cases. Inputs change and outputs are sampled on the
// falling clock edge.
module tb_alu_arbiter;

  logic clk;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  alu_arbiter_if bus ();

  alu_arbiter #(.MUL_LAT(3)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference ALU.
  always_comb begin
    case (bus.alu_ctrl_o)
      3'b000:  bus.alu_data_i = bus.alu_data1_o & bus.alu_data2_o;
      3'b001:  bus.alu_data_i = bus.alu_data1_o | bus.alu_data2_o;
      3'b010:  bus.alu_data_i = bus.alu_data1_o + bus.alu_data2_o;
      3'b110:  bus.alu_data_i = bus.alu_data1_o - bus.alu_data2_o;
      3'b101:  bus.alu_data_i = bus.alu_data1_o * bus.alu_data2_o;
      default: bus.alu_data_i = 32'd0;
    endcase
  end

  task automatic check_word(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_req(input logic id, input logic v, input logic [31:0] d1,
                         input logic [31:0] d2, input logic [2:0] c);
    if (id) begin
      bus.req1_valid_i = v;
      bus.req1_data1_i = d1;
      bus.req1_data2_i = d2;
      bus.req1_ctrl_i  = c;
    end else begin
      bus.req0_valid_i = v;
      bus.req0_data1_i = d1;
      bus.req0_data2_i = d2;
      bus.req0_ctrl_i  = c;
    end
  endtask

  // One complete op from a single requester with rsp_ready_i held high.
  task automatic run_op(input string tag, input logic id, input logic [31:0] d1,
                        input logic [31:0] d2, input logic [2:0] c,
                        input int lat, input logic [31:0] exp);
    set_req(id, 1'b1, d1, d2, c);
    #1;
    check_bit({tag, "_ready"}, id ? bus.req1_ready_o : bus.req0_ready_o, 1'b1);
    tick();
    set_req(id, 1'b0, d1, d2, c);
    check_word({tag, "_alu_ctrl"}, {29'd0, bus.alu_ctrl_o}, {29'd0, c});
    for (int i = 1; i < lat; i++) begin
      check_bit({tag, "_early_valid"}, bus.rsp_valid_o, 1'b0);
      tick();
    end
    tick();
    check_bit({tag, "_rsp_valid"}, bus.rsp_valid_o, 1'b1);
    check_word({tag, "_rsp_data"}, bus.rsp_data_o, exp);
    check_bit({tag, "_rsp_id"}, bus.rsp_id_o, id);
    tick();
    check_bit({tag, "_done"}, bus.rsp_valid_o, 1'b0);
  endtask

  initial begin
    rst             = 1'b1;
    bus.rsp_ready_i = 1'b1;
    set_req(1'b0, 1'b0, 32'd0, 32'd0, 3'b000);
    set_req(1'b1, 1'b0, 32'd0, 32'd0, 3'b000);

    // Reset state, with requester 0 already valid: ready must stay low.
    set_req(1'b0, 1'b1, 32'd5, 32'd7, 3'b010);
    @(negedge clk);
    #1;
    check_bit ("rst_ready0",    bus.req0_ready_o, 1'b0);
    check_bit ("rst_ready1",    bus.req1_ready_o, 1'b0);
    check_bit ("rst_busy",      bus.busy_o,       1'b0);
    check_bit ("rst_rsp_valid", bus.rsp_valid_o,  1'b0);
    check_word("rst_rsp_data",  bus.rsp_data_o,   32'd0);
    check_bit ("rst_rsp_id",    bus.rsp_id_o,     1'b0);
    check_word("rst_alu_data1", bus.alu_data1_o,  32'd0);
    check_word("rst_alu_data2", bus.alu_data2_o,  32'd0);
    check_word("rst_alu_ctrl",  {29'd0, bus.alu_ctrl_o}, 32'd0);

    // Single add 5+7.
    rst = 1'b0;
    #1;
    check_bit("add_ready0", bus.req0_ready_o, 1'b1);
    check_bit("add_ready1", bus.req1_ready_o, 1'b0);
    tick();
    check_bit ("add_busy",      bus.busy_o,       1'b1);
    check_bit ("add_exec_rdy",  bus.req0_ready_o, 1'b0);
    check_word("add_alu_data1", bus.alu_data1_o,  32'd5);
    check_word("add_alu_data2", bus.alu_data2_o,  32'd7);
    check_bit ("add_no_rsp",    bus.rsp_valid_o,  1'b0);
    set_req(1'b0, 1'b0, 32'd5, 32'd7, 3'b010);
    tick();
    check_bit ("add_rsp_valid", bus.rsp_valid_o, 1'b1);
    check_word("add_rsp_data",  bus.rsp_data_o,  32'd12);
    check_bit ("add_rsp_id",    bus.rsp_id_o,    1'b0);
    tick();
    check_bit("add_idle_valid", bus.rsp_valid_o, 1'b0);
    check_bit("add_idle_busy",  bus.busy_o,      1'b0);
    check_word("add_data_held", bus.rsp_data_o,  32'd12);

    // Multiply overflow 0x10000 * 0x10000 -> low word 0.
    run_op("mul_ovf", 1'b0, 32'h0001_0000, 32'h0001_0000, 3'b101, 3, 32'd0);

    // Multiply latency: 6*7 from requester 1, result exactly 3 edges after accept.
    set_req(1'b1, 1'b1, 32'd6, 32'd7, 3'b101);
    #1;
    check_bit("mul_ready1", bus.req1_ready_o, 1'b1);
    tick();
    set_req(1'b1, 1'b0, 32'd6, 32'd7, 3'b101);
    check_bit ("mul_busy",     bus.busy_o, 1'b1);
    check_word("mul_alu_ctrl", {29'd0, bus.alu_ctrl_o}, 32'd5);
    tick();
    check_bit("mul_k1_valid", bus.rsp_valid_o, 1'b0);
    tick();
    check_bit("mul_k2_valid", bus.rsp_valid_o, 1'b0);
    check_bit("mul_k2_busy",  bus.busy_o,      1'b1);
    tick();
    check_bit ("mul_k3_valid", bus.rsp_valid_o, 1'b1);
    check_word("mul_k3_data",  bus.rsp_data_o,  32'd42);
    check_bit ("mul_k3_id",    bus.rsp_id_o,    1'b1);
    tick();

    // Reset in the second EXEC cycle of a multiply.
    set_req(1'b0, 1'b1, 32'd3, 32'd4, 3'b101);
    tick();
    set_req(1'b0, 1'b0, 32'd3, 32'd4, 3'b101);
    tick();
    check_bit("rmul_busy_before", bus.busy_o, 1'b1);
    rst = 1'b1;
    #1;
    check_bit ("rmul_busy",      bus.busy_o,      1'b0);
    check_bit ("rmul_rsp_valid", bus.rsp_valid_o, 1'b0);
    check_word("rmul_rsp_data",  bus.rsp_data_o,  32'd0);
    check_bit ("rmul_rsp_id",    bus.rsp_id_o,    1'b0);
    check_word("rmul_alu_data1", bus.alu_data1_o, 32'd0);
    check_word("rmul_alu_data2", bus.alu_data2_o, 32'd0);
    check_word("rmul_alu_ctrl",  {29'd0, bus.alu_ctrl_o}, 32'd0);
    tick();
    check_bit("rmul_no_rsp", bus.rsp_valid_o, 1'b0);

    // Contention from reset: both valid, grants alternate starting with 0.
    set_req(1'b0, 1'b1, 32'd10,   32'd3,   3'b110);
    set_req(1'b1, 1'b1, 32'h0000_00F0, 32'h0000_000F, 3'b001);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      #1;
      check_bit("cont_ready0", bus.req0_ready_o, (i % 2) == 0);
      check_bit("cont_ready1", bus.req1_ready_o, (i % 2) == 1);
      tick();
      check_bit("cont_busy", bus.busy_o, 1'b1);
      tick();
      check_bit ("cont_rsp_valid", bus.rsp_valid_o, 1'b1);
      check_bit ("cont_rsp_id",    bus.rsp_id_o,    (i % 2) == 1);
      check_word("cont_rsp_data",  bus.rsp_data_o,  (i % 2) == 0 ? 32'd7 : 32'h0000_00FF);
      tick();
    end
    set_req(1'b0, 1'b0, 32'd10, 32'd3, 3'b110);
    set_req(1'b1, 1'b0, 32'h0000_00F0, 32'h0000_000F, 3'b001);

    // Backpressure: add 1+1 held in RESP for 5 cycles while requester 1 waits.
    bus.rsp_ready_i = 1'b0;
    set_req(1'b0, 1'b1, 32'd1, 32'd1, 3'b010);
    #1;
    check_bit("bp_ready0", bus.req0_ready_o, 1'b1);
    tick();
    set_req(1'b0, 1'b0, 32'd1, 32'd1, 3'b010);
    set_req(1'b1, 1'b1, 32'hFFFF_FFFF, 32'd1, 3'b010);
    tick();
    for (int i = 0; i < 5; i++) begin
      check_bit ("bp_hold_valid",  bus.rsp_valid_o,  1'b1);
      check_word("bp_hold_data",   bus.rsp_data_o,   32'd2);
      check_bit ("bp_hold_id",     bus.rsp_id_o,     1'b0);
      check_bit ("bp_hold_ready1", bus.req1_ready_o, 1'b0);
      tick();
    end
    bus.rsp_ready_i = 1'b1;
    tick();
    check_bit("bp_hs_valid",  bus.rsp_valid_o,  1'b0);
    check_bit("bp_hs_busy",   bus.busy_o,       1'b0);
    check_bit("bp_hs_ready1", bus.req1_ready_o, 1'b1);
    tick();
    set_req(1'b1, 1'b0, 32'hFFFF_FFFF, 32'd1, 3'b010);
    check_bit ("bp_acc_busy",  bus.busy_o,      1'b1);
    check_word("bp_acc_data1", bus.alu_data1_o, 32'hFFFF_FFFF);
    tick();
    // Boundary: 0xFFFFFFFF + 1 wraps to 0.
    check_bit ("wrap_valid", bus.rsp_valid_o, 1'b1);
    check_word("wrap_data",  bus.rsp_data_o,  32'd0);
    check_bit ("wrap_id",    bus.rsp_id_o,    1'b1);
    tick();

    // Remaining boundaries and ops.
    run_op("sub_wrap", 1'b0, 32'd0, 32'd1, 3'b110, 1, 32'hFFFF_FFFF);
    run_op("undef",    1'b1, 32'd3, 32'd5, 3'b011, 1, 32'd0);
    run_op("and",      1'b0, 32'h0000_F0F0, 32'h0000_FF00, 3'b000, 1, 32'h0000_F000);
    run_op("mul_neg",  1'b1, 32'hFFFF_FFFF, 32'd2, 3'b101, 3, 32'hFFFF_FFFE);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Safety net so the run can never hang.
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
